// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and constants for the multi-channel clock
//               divider: output-mode encoding, the reset divisor and a
//               helper that sizes the channel-select field.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Output shaping per channel: square toggles on every period boundary,
    // pulse mirrors the boundary strobe.
    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Divisor loaded into every channel while reset is asserted.
    localparam int unsigned DEFAULT_DIV = 32'd5000000;

    // Width of a channel index; never narrower than one bit so a
    // single-channel build still has a legal select port.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel. Holds the active divisor/mode plus a
//               one-deep pending slot; a pending update is promoted only at a
//               period boundary (or whenever the channel is disabled) so no
//               period is ever truncated or stretched.
// Ports       : clk       - system clock, rising edge
//               reset     - asynchronous, active-high
//               i_en      - run enable
//               i_wr      - validated configuration write for this channel
//               i_div     - new divisor (never zero, filtered upstream)
//               i_mode    - new output mode
//               o_clk_out - divided clock (registered)
//               o_tick    - period-boundary strobe (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_div,
    input  mode_e            i_mode,
    output logic             o_clk_out,
    output logic             o_tick
);

    localparam logic [WIDTH-1:0] c_reset_div = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    mode_e            r_mode;
    logic             r_pend;
    logic [WIDTH-1:0] r_pend_div;
    mode_e            r_pend_mode;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_wrap;
    logic [WIDTH-1:0] w_next_div;
    mode_e            w_next_mode;

    // Last count of the current period reached while running.
    assign w_wrap = i_en && (r_cnt == (r_div - WIDTH'(1)));

    // Configuration that governs the next period when a promotion happens.
    assign w_next_div  = r_pend ? r_pend_div  : r_div;
    assign w_next_mode = r_pend ? r_pend_mode : r_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_div       <= c_reset_div;
            r_mode      <= MODE_SQUARE;
            r_pend      <= 1'b0;
            r_pend_div  <= c_reset_div;
            r_pend_mode <= MODE_SQUARE;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
        end else if (!i_en) begin
            // Idle: park at count 0 with quiet outputs. A fresh write wins
            // over anything still pending and takes effect right away.
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
            r_pend    <= 1'b0;
            if (i_wr) begin
                r_div  <= i_div;
                r_mode <= i_mode;
            end else begin
                r_div  <= w_next_div;
                r_mode <= w_next_mode;
            end
        end else begin
            if (w_wrap) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_div  <= w_next_div;
                r_mode <= w_next_mode;
                // The boundary output already follows the incoming mode so a
                // switch to pulse produces a clean strobe at the boundary.
                r_clk_out <= (w_next_mode == MODE_PULSE) ? 1'b1 : ~r_clk_out;
            end else begin
                r_cnt     <= r_cnt + WIDTH'(1);
                r_tick    <= 1'b0;
                r_clk_out <= (r_mode == MODE_PULSE) ? 1'b0 : r_clk_out;
            end

            // A write landing on the boundary edge waits for the next one.
            if (i_wr) begin
                r_pend      <= 1'b1;
                r_pend_div  <= i_div;
                r_pend_mode <= i_mode;
            end else if (w_wrap) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi
// Description : NCH independent programmable clock dividers. The top decodes
//               configuration writes, rejects illegal ones and reports them
//               on cfg_err one cycle later.
// Ports       : clk      - system clock, rising edge
//               reset    - asynchronous, active-high
//               en       - per-channel run enable
//               cfg_we   - configuration write strobe
//               cfg_ch   - target channel
//               cfg_div  - new divisor (0 is illegal)
//               cfg_mode - new mode (0 square, 1 pulse)
//               clk_out  - divided clocks
//               tick     - per-channel period-boundary strobes
//               cfg_err  - rejected-write strobe
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH-1:0]             en,
    input  logic                       cfg_we,
    input  logic [ch_width(NCH)-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]           cfg_div,
    input  logic                       cfg_mode,
    output logic [NCH-1:0]             clk_out,
    output logic [NCH-1:0]             tick,
    output logic                       cfg_err
);

    logic  w_ch_ok;
    logic  w_div_ok;
    logic  w_cfg_ok;
    logic  r_cfg_err;
    mode_e w_mode;

    // The select field can encode indices beyond the last channel when NCH
    // is not a power of two; such writes are rejected like a zero divisor.
    assign w_ch_ok  = (int'(cfg_ch) < NCH);
    assign w_div_ok = (cfg_div != '0);
    assign w_cfg_ok = cfg_we && w_ch_ok && w_div_ok;
    assign w_mode   = mode_e'(cfg_mode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !(w_ch_ok && w_div_ok);
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic w_wr;

        assign w_wr = w_cfg_ok && (int'(cfg_ch) == gi);

        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_en      (en[gi]),
            .i_wr      (w_wr),
            .i_div     (cfg_div),
            .i_mode    (w_mode),
            .o_clk_out (clk_out[gi]),
            .o_tick    (tick[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_multi
// Description : Self-checking bench for clk_div_multi. A behavioural model
//               tracks each channel's position inside its period and the
//               configuration rules; DUT outputs are compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int NCH   = 5;
    localparam int WIDTH = 16;
    localparam int DDIV  = 5;
    localparam int CHW   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   en;
    logic             cfg_we;
    logic [CHW-1:0]   cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_mode;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic             cfg_err;

    clk_div_multi #(
        .NCH         (NCH),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .clk_out  (clk_out),
        .tick     (tick),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pos   [NCH];  // cycles elapsed in the current period
    int m_div   [NCH];
    bit m_pulse [NCH];
    bit m_pend  [NCH];
    int m_pdiv  [NCH];
    bit m_ppulse[NCH];
    bit m_out   [NCH];
    bit m_tick  [NCH];
    bit m_err;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pos[c] = 0;  m_div[c] = DDIV; m_pulse[c] = 0;
            m_pend[c] = 0; m_pdiv[c] = DDIV; m_ppulse[c] = 0;
            m_out[c] = 0;  m_tick[c] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_edge();
        bit bad, wr, boundary;
        bad   = cfg_we && (cfg_div == 0 || int'(cfg_ch) >= NCH);
        m_err = bad;
        for (int c = 0; c < NCH; c++) begin
            wr = cfg_we && !bad && (int'(cfg_ch) == c);
            if (!en[c]) begin
                m_pos[c] = 0; m_tick[c] = 0; m_out[c] = 0;
                if (wr) begin
                    m_div[c] = int'(cfg_div); m_pulse[c] = cfg_mode;
                end else if (m_pend[c]) begin
                    m_div[c] = m_pdiv[c]; m_pulse[c] = m_ppulse[c];
                end
                m_pend[c] = 0;
            end else begin
                boundary = (m_pos[c] + 1 == m_div[c]);
                if (boundary) begin
                    m_pos[c]  = 0;
                    m_tick[c] = 1;
                    if (m_pend[c]) begin
                        m_div[c] = m_pdiv[c]; m_pulse[c] = m_ppulse[c]; m_pend[c] = 0;
                    end
                    m_out[c] = m_pulse[c] ? 1'b1 : !m_out[c];
                end else begin
                    m_pos[c]  = m_pos[c] + 1;
                    m_tick[c] = 0;
                    if (m_pulse[c]) m_out[c] = 0;
                end
                if (wr) begin
                    m_pend[c] = 1; m_pdiv[c] = int'(cfg_div); m_ppulse[c] = cfg_mode;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_out[c]));
            check($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
        end
        check("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later,
    // returns at the falling edge ready for new inputs.
    task automatic cycle();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write(input int ch, input int dv, input bit md);
        cfg_we = 1; cfg_ch = CHW'(ch); cfg_div = WIDTH'(dv); cfg_mode = md;
        cycle();
        cfg_we = 0;
    endtask

    task automatic async_reset();
        #2 reset = 1;
        model_reset();
        #1;
        check("reset_clk_out", 32'(clk_out), 32'(0));
        check("reset_tick", 32'(tick), 32'(0));
        check("reset_cfg_err", 32'(cfg_err), 32'(0));
        @(negedge clk);
        reset = 0;
    endtask

    int tcount;

    initial begin
        reset = 1; en = '0; cfg_we = 0; cfg_ch = '0; cfg_div = '0; cfg_mode = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("reset_clk_out", 32'(clk_out), 32'(0));
        check("reset_tick", 32'(tick), 32'(0));
        check("reset_cfg_err", 32'(cfg_err), 32'(0));
        reset = 0;
        run(3);

        // Default divisor on channel 0: 4 ticks in 20 cycles, first on cycle 5.
        en = 5'b00001;
        tcount = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (tick[0]) tcount++;
            if (i == 4) check("ch0_no_early_tick", 32'(tcount), 32'(0));
        end
        check("ch0_tick_count", 32'(tcount), 32'(4));

        // Reconfigure a running channel: current period finishes first.
        en = 5'b01111;
        run(7);
        write(1, 3, 1);
        run(20);

        // Illegal writes: zero divisor and out-of-range channel.
        write(2, 0, 0);
        check("cfg_err_div0", 32'(cfg_err), 32'(1));
        run(1);
        check("cfg_err_clear", 32'(cfg_err), 32'(0));
        write(6, 4, 0);
        check("cfg_err_ch_range", 32'(cfg_err), 32'(1));
        run(10);

        // Divide by one in square mode on channel 3.
        write(3, 1, 0);
        run(12);
        tcount = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            tcount += int'(tick[3]);
        end
        check("ch3_tick_const", 32'(tcount), 32'(6));

        // Drop enable mid-period, raise again after 4 cycles.
        run(2);
        en[0] = 0;
        run(4);
        en[0] = 1;
        run(12);

        // Write to a disabled channel takes effect at once.
        en[4] = 0;
        write(4, 2, 1);
        en[4] = 1;
        run(8);

        // Asynchronous reset mid-period, then restart with defaults.
        write(0, 7, 0);
        run(2);
        async_reset();
        en = '1;
        run(25);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 29) == 0) en[c] = ~en[c];
            cfg_we   = ($urandom_range(0, 4) == 0);
            cfg_ch   = CHW'($urandom_range(0, 7));
            cfg_div  = WIDTH'($urandom_range(0, 7));
            cfg_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 599) == 0) begin
                cfg_we = 0;
                async_reset();
            end else begin
                cycle();
            end
        end
        cfg_we = 0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #2000000;
        $display("FAIL timeout observed=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter WIDTH, default 32, divisor and counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 5000000, divisor loaded into every channel at reset.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 en  input  NCH  per-channel run enable.
REQ-007 cfg_we  input  1  single-cycle configuration write strobe.
REQ-008 cfg_ch  input  max(1,clog2(NCH))  target channel of a configuration write.
REQ-009 cfg_div  input  WIDTH  new divisor value.
REQ-010 cfg_mode  input  1  new output mode: 0 = square (toggle), 1 = pulse.
REQ-011 clk_out  output  NCH  divided clock per channel, registered.
REQ-012 tick  output  NCH  one-cycle strobe per channel at each period boundary, registered.
REQ-013 cfg_err  output  1  one-cycle strobe flagging a rejected configuration write.

Function
REQ-014 Each channel SHALL hold an active divisor, active mode, pending divisor/mode, a pending flag and a WIDTH-bit counter.
REQ-015 While enabled, a channel counter SHALL count 0..div-1 and wrap to 0; tick SHALL be 1 for exactly the cycle following count==div-1.
REQ-016 Square mode: clk_out SHALL toggle on every tick (period 2*div cycles, 50% duty).
REQ-017 Pulse mode: clk_out SHALL equal tick (high 1 cycle in every div).
REQ-018 div==1 SHALL give tick high every cycle; square-mode clk_out toggles every cycle.
REQ-019 A write with cfg_div==0 or cfg_ch>=NCH SHALL be ignored and SHALL assert cfg_err the next cycle.
REQ-020 A valid write to an enabled channel SHALL be stored as pending and become active at that channel's next wrap, with no truncated or stretched period.
REQ-021 A valid write to a disabled channel SHALL become active immediately.
REQ-022 A second write before the pending one is applied SHALL overwrite it (last write wins).
REQ-023 en low SHALL clear the counter to 0, force clk_out and tick to 0 next cycle, and apply any pending config.
REQ-024 On en rising, first tick SHALL occur div cycles later (counter starts at 0).
REQ-025 Channels SHALL be fully independent; a write to one SHALL not disturb another's phase.

Reset
REQ-026 On reset: counters 0, active divisor DEFAULT_DIV, mode square, pending flags clear, clk_out 0, tick 0, cfg_err 0.
REQ-027 Reset asserted mid-period SHALL discard the partial period and pending writes; operation restarts from count 0 after release.

Structure
REQ-028 Package clk_div_pkg SHALL hold the mode enum (MODE_SQUARE, MODE_PULSE) and the DEFAULT_DIV constant.
REQ-029 Per-channel logic SHALL be sub-module clk_div_chan, instantiated NCH times by generate; top holds write decode and cfg_err.

Verification
REQ-030 DEFAULT_DIV=5, en[0]=1 after reset -> tick[0] every 5 cycles, clk_out[0] period 10, 50% duty.
REQ-031 Write ch1 div=3 mode=pulse while running at div=5 -> current 5-cycle period completes, then tick[1]=clk_out[1] every 3 cycles.
REQ-032 Write cfg_div=0 to ch2 -> cfg_err high 1 cycle, ch2 period unchanged.
REQ-033 div=1 square on ch3 -> clk_out[3] toggles each cycle, tick[3] constant 1.
REQ-034 Drop en[0] mid-period, raise 4 cycles later with div=5 -> outputs 0 while low, first tick 5 cycles after rise.
REQ-035 Assert reset mid-period on all channels -> all outputs 0 same cycle, divisors back to DEFAULT_DIV.
